// File: rtl/axis_to_ddr_top.sv
// axis_to_ddr_top: packs a 32-bit AXI4-Stream into 128-bit words, buffers them in a
// FIFO and writes them to DDR as fixed-length INCR bursts from a base address.
// Optional build macro AXIS2DDR_BRESP_ERR_EN adds a sticky bresp_err output.
// Handshake rule: a transfer happens on a rising edge where VALID and READY are both 1;
// a VALID driven by this block stays high until that edge.
module axis_to_ddr_top #(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h10000000,
  parameter int C_M_AXI_BURST_LEN = 16,
  parameter int C_M_AXI_ID_WIDTH = 1,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_M_AXI_AWUSER_WIDTH = 0,
  parameter int C_M_AXI_ARUSER_WIDTH = 0,
  parameter int C_M_AXI_WUSER_WIDTH = 0,
  parameter int C_M_AXI_RUSER_WIDTH = 0,
  parameter int C_M_AXI_BUSER_WIDTH = 0,
  localparam int AWU_W = (C_M_AXI_AWUSER_WIDTH > 0) ? C_M_AXI_AWUSER_WIDTH : 1,
  localparam int ARU_W = (C_M_AXI_ARUSER_WIDTH > 0) ? C_M_AXI_ARUSER_WIDTH : 1,
  localparam int WU_W  = (C_M_AXI_WUSER_WIDTH > 0) ? C_M_AXI_WUSER_WIDTH : 1,
  localparam int RU_W  = (C_M_AXI_RUSER_WIDTH > 0) ? C_M_AXI_RUSER_WIDTH : 1,
  localparam int BU_W  = (C_M_AXI_BUSER_WIDTH > 0) ? C_M_AXI_BUSER_WIDTH : 1
) (
  input  logic                            S_AXIS_ACLK,
  input  logic                            S_AXIS_ARESETN,
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  input  logic [31:0]                     S_AXIS_TDATA,
  input  logic [3:0]                      S_AXIS_TSTRB,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TUSER,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic [AWU_W-1:0]                M_AXI_AWUSER,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic [WU_W-1:0]                 M_AXI_WUSER,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic [BU_W-1:0]                 M_AXI_BUSER,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic [ARU_W-1:0]                M_AXI_ARUSER,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic [RU_W-1:0]                 M_AXI_RUSER,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  output logic [1:0]                      dbg_state
`ifdef AXIS2DDR_BRESP_ERR_EN
  ,
  output logic                            bresp_err
`endif
);

  localparam int AW     = C_M_AXI_ADDR_WIDTH;
  localparam int DW     = C_M_AXI_DATA_WIDTH;
  localparam int SW     = DW / 8;
  localparam int BL     = C_M_AXI_BURST_LEN;
  localparam int DEPTH  = 2 * BL;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = $clog2(BL + 1);
  localparam logic [AW-1:0] BURST_BYTES = AW'(BL * SW);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  logic clk, rst_n;
  assign clk   = S_AXIS_ACLK;
  assign rst_n = S_AXIS_ARESETN;

  state_t              state;
  logic                tready_q, awvalid_q, wvalid_q, wlast_q, bready_q, sof_pending;
  logic [AW-1:0]       awaddr_q;
  logic [BEAT_W-1:0]   beat_cnt, take_cnt;
  logic [1:0]          lane, lane_eff;
  logic [DW-1:0]       pack_data, base_data, word_data;
  logic [SW-1:0]       pack_strb, base_strb, word_strb;
  logic                beat_acc, push, pop, padding, sof_acc;
  logic [DW+SW:0]      mem [DEPTH];
  logic [DW+SW:0]      head;
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count, count_next, last_cnt, last_cnt_next;

  assign beat_acc = S_AXIS_TVALID & tready_q;
  assign sof_acc  = beat_acc & S_AXIS_TUSER;

  // Merge the incoming beat into the word being packed; a start-of-frame beat
  // throws away any partial word and becomes lane 0 of a fresh one.
  always_comb begin
    base_data = S_AXIS_TUSER ? '0 : pack_data;
    base_strb = S_AXIS_TUSER ? '0 : pack_strb;
    lane_eff  = S_AXIS_TUSER ? 2'd0 : lane;
    word_data = base_data | (DW'(S_AXIS_TDATA) << {lane_eff, 5'b00000});
    word_strb = base_strb | (SW'(4'hF) << {lane_eff, 2'b00});
    push      = beat_acc & ((lane_eff == 2'd3) | S_AXIS_TLAST);
  end

  // Packing register: holds lanes collected so far for the current word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_data <= '0;
      pack_strb <= '0;
      lane      <= 2'd0;
    end else if (beat_acc) begin
      if (push) begin
        pack_data <= '0;
        pack_strb <= '0;
        lane      <= 2'd0;
      end else begin
        pack_data <= word_data;
        pack_strb <= word_strb;
        lane      <= lane_eff + 2'd1;
      end
    end
  end

  // FIFO storage: {last-of-frame flag, strobes, data}.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {S_AXIS_TLAST, word_strb, word_data};
  end

  assign head    = mem[rd_ptr];
  assign padding = (beat_cnt >= take_cnt);
  assign pop     = (state == ST_W) & wvalid_q & M_AXI_WREADY & ~padding;

  always_comb begin
    count_next    = count + CNT_W'(push) - CNT_W'(pop);
    last_cnt_next = last_cnt + CNT_W'(push & S_AXIS_TLAST) - CNT_W'(pop & head[DW+SW]);
  end

  // FIFO pointers, occupancy, count of frame-ending words inside, and TREADY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      last_cnt <= '0;
      tready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count    <= count_next;
      last_cnt <= last_cnt_next;
      tready_q <= (count_next != CNT_W'(DEPTH));
    end
  end

  // Burst engine: one burst at a time, AW then W beats then B response.
  // A flush burst (frame end with fewer than BL words queued) pads with empty beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      awvalid_q   <= 1'b0;
      awaddr_q    <= C_M_TARGET_SLAVE_BASE_ADDR;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      beat_cnt    <= '0;
      take_cnt    <= '0;
      sof_pending <= 1'b0;
    end else begin
      if (sof_acc) sof_pending <= 1'b1;
      case (state)
        ST_IDLE: begin
          if ((count >= CNT_W'(BL)) || (last_cnt != '0)) begin
            awvalid_q <= 1'b1;
            take_cnt  <= (count >= CNT_W'(BL)) ? BEAT_W'(BL) : BEAT_W'(count);
            if (sof_pending) begin
              awaddr_q    <= C_M_TARGET_SLAVE_BASE_ADDR;
              sof_pending <= sof_acc;
            end
            state <= ST_AW;
          end
        end
        ST_AW: begin
          if (M_AXI_AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (BL == 1);
            beat_cnt  <= '0;
            state     <= ST_W;
          end
        end
        ST_W: begin
          if (M_AXI_WREADY) begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state    <= ST_B;
            end else begin
              wlast_q <= (beat_cnt == BEAT_W'(BL - 2));
            end
          end
        end
        default: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            awaddr_q <= awaddr_q + BURST_BYTES;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef AXIS2DDR_BRESP_ERR_EN
  // Sticky flag for any non-OKAY write response; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bresp_err <= 1'b0;
    else if (M_AXI_BVALID && bready_q && (M_AXI_BRESP != 2'b00)) bresp_err <= 1'b1;
  end
`endif

  assign S_AXIS_TREADY = tready_q;
  assign dbg_state     = state;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = 8'(BL - 1);
  assign M_AXI_AWSIZE  = 3'd4;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0010;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = padding ? '0 : head[DW-1:0];
  assign M_AXI_WSTRB   = padding ? '0 : head[DW+SW-1:DW];
  assign M_AXI_WLAST   = wlast_q;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = 3'd0;
  assign M_AXI_ARBURST = 2'b00;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;

  // Inputs with no function in this bridge are folded into one dummy signal.
  logic unused_inputs;
  assign unused_inputs = ^{M_AXI_ACLK, M_AXI_ARESETN, S_AXIS_TSTRB, M_AXI_BID, M_AXI_BUSER,
`ifndef AXIS2DDR_BRESP_ERR_EN
                           M_AXI_BRESP,
`endif
                           M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP,
                           M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID};

endmodule

// File: tb/tb_axis_to_ddr_top.sv
// tb_axis_to_ddr_top: directed bench for axis_to_ddr_top with a simple AXI write slave.
module tb_axis_to_ddr_top;

  localparam logic [31:0] BASE = 32'h10000000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic         s_tvalid = 1'b0, s_tready, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [31:0]  s_tdata = '0;
  logic [3:0]   s_tstrb = 4'hF;
  logic [0:0]   awid, awuser, wuser, arid, aruser;
  logic [31:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, awprot, arsize, arprot;
  logic [1:0]   awburst, arburst;
  logic         awlock, awvalid, arlock, arvalid, rready;
  logic [3:0]   awcache, awqos, arcache, arqos;
  logic         awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [127:0] wdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, bready;
  logic [0:0]   bid = '0, buser = '0, rid = '0, ruser = '0;
  logic [1:0]   bresp = 2'b00, rresp = 2'b00;
  logic         arready = 1'b0, rlast = 1'b0, rvalid = 1'b0;
  logic [127:0] rdata = '0;
  logic [1:0]   dbg_state;
`ifdef AXIS2DDR_BRESP_ERR_EN
  logic         bresp_err;
`endif

  axis_to_ddr_top dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready), .S_AXIS_TDATA(s_tdata),
    .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast), .S_AXIS_TUSER(s_tuser),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWUSER(awuser),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WUSER(wuser),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BUSER(buser), .M_AXI_BVALID(bvalid),
    .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARUSER(aruser),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RUSER(ruser), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
    .dbg_state(dbg_state)
`ifdef AXIS2DDR_BRESP_ERR_EN
    , .bresp_err(bresp_err)
`endif
  );

  // ---------------- counters, scoreboard queues ----------------
  int assert_cnt = 0;
  int fail_cnt   = 0;
  int cyc = 0, s_acc_cnt = 0, aw_cnt = 0, w_last_cnt = 0, b_hs_cnt = 0;
  bit hold_aw = 1'b0, stall_en = 1'b0;
  logic [1:0] resp_val = 2'b00;

  logic [31:0]  act_addr_q[$];
  logic [7:0]   act_len_q[$];
  logic [2:0]   act_size_q[$];
  logic [1:0]   act_burst_q[$];
  logic [127:0] act_data_q[$];
  logic [15:0]  act_strb_q[$];
  logic [0:0]   act_last_q[$];
  logic [31:0]  exp_addr_q[$];
  logic [127:0] exp_data_q[$];
  logic [15:0]  exp_strb_q[$];
  logic [0:0]   exp_last_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- AXI slave: drive at negedge ----------------
  always @(negedge clk) begin
    cyc++;
    awready = !hold_aw && (!stall_en || (cyc % 3 != 0));
    wready  = !stall_en || (cyc % 4 != 1);
    bvalid  = (w_last_cnt > b_hs_cnt);
    bresp   = resp_val;
  end

  // ---------------- monitor: sample handshakes at posedge ----------------
  always @(posedge clk) begin
    if (rst_n) begin
      if (s_tvalid && s_tready) s_acc_cnt++;
      if (awvalid && awready) begin
        check("aw_one_outstanding", aw_cnt, b_hs_cnt);
        act_addr_q.push_back(awaddr);
        act_len_q.push_back(awlen);
        act_size_q.push_back(awsize);
        act_burst_q.push_back(awburst);
        aw_cnt++;
      end
      if (wvalid && wready) begin
        check("w_after_aw", aw_cnt, b_hs_cnt + 1);
        act_data_q.push_back(wdata);
        act_strb_q.push_back(wstrb);
        act_last_q.push_back(wlast);
        if (wlast) w_last_cnt++;
      end
      if (bvalid && bready) b_hs_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beats(input int n, input int first, input bit last_end, input bit user_first);
    int start, tmo;
    for (int i = 0; i < n; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 32'(first + i);
      s_tlast  = last_end && (i == n - 1);
      s_tuser  = user_first && (i == 0);
      start = s_acc_cnt;
      tmo = 0;
      do begin
        @(negedge clk);
        tmo++;
      end while (s_acc_cnt == start && tmo < 2000);
      if (s_acc_cnt == start) begin
        check("tready_timeout", 0, 1);
        break;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic wait_bursts(input int n);
    int tmo = 0;
    while (b_hs_cnt < n && tmo < 5000) begin
      @(negedge clk);
      tmo++;
    end
    check($sformatf("burst_%0d_done", n), (b_hs_cnt >= n), 1);
  endtask

  task automatic exp_full_burst(input logic [31:0] addr, input int first);
    int v;
    exp_addr_q.push_back(addr);
    for (int i = 0; i < 16; i++) begin
      v = first + 4 * i;
      exp_data_q.push_back({32'(v + 3), 32'(v + 2), 32'(v + 1), 32'(v)});
      exp_strb_q.push_back(16'hFFFF);
      exp_last_q.push_back(i == 15);
    end
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int start_acc;
    int flush_idx;
    int tuser_idx;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_wlast", wlast, 0);
    check("rst_bready", bready, 0);
    check("rst_tready", s_tready, 0);
    check("rst_awaddr", awaddr, BASE);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awcache", awcache, 4'b0010);
    check("rst_state", dbg_state, 0);
`ifdef AXIS2DDR_BRESP_ERR_EN
    check("rst_bresp_err", bresp_err, 0);
`endif
    rst_n = 1'b1;
    check("tready_at_release", s_tready, 0);
    @(negedge clk);
    check("tready_after_release", s_tready, 1);

    // 64 beats -> one full burst at base
    send_beats(64, 0, 1'b0, 1'b0);
    exp_full_burst(BASE, 0);
    wait_bursts(1);
    repeat (40) @(negedge clk);
    check("single_aw_only", aw_cnt, 1);
    check("first_aw_addr", act_addr_q[0], 32'h10000000);
    check("first_aw_len", act_len_q[0], 8'd15);
    check("first_aw_size", act_size_q[0], 3'd4);
    check("first_beat_data", act_data_q[0], {32'd3, 32'd2, 32'd1, 32'd0});
    check("beat15_wlast", act_last_q[15], 1);
    check("beat14_wlast", act_last_q[14], 0);

    // next 64 beats -> second burst 256 bytes later
    send_beats(64, 64, 1'b0, 1'b0);
    exp_full_burst(BASE + 32'h100, 64);
    wait_bursts(2);
    check("second_aw_addr", act_addr_q[1], 32'h10000100);

    // AW held off: FIFO fills to 32 words, TREADY drops, then stalls with no loss
    hold_aw = 1'b1;
    start_acc = s_acc_cnt;
    fork
      send_beats(192, 128, 1'b0, 1'b0);
      begin
        repeat (250) @(negedge clk);
        check("fill_beats_accepted", s_acc_cnt - start_acc, 128);
        check("fill_tready_low", s_tready, 0);
        check("fill_no_new_aw", aw_cnt, 2);
        hold_aw  = 1'b0;
        stall_en = 1'b1;
      end
    join
    exp_full_burst(BASE + 32'h200, 128);
    exp_full_burst(BASE + 32'h300, 192);
    exp_full_burst(BASE + 32'h400, 256);
    wait_bursts(5);

    // frame end on 6th beat -> two words then 14 padding beats
    flush_idx = exp_data_q.size();
    send_beats(6, 32'hA0, 1'b1, 1'b0);
    exp_addr_q.push_back(BASE + 32'h500);
    exp_data_q.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
    exp_strb_q.push_back(16'hFFFF);
    exp_last_q.push_back(1'b0);
    exp_data_q.push_back({32'h0, 32'h0, 32'hA5, 32'hA4});
    exp_strb_q.push_back(16'h00FF);
    exp_last_q.push_back(1'b0);
    for (int i = 2; i < 16; i++) begin
      exp_data_q.push_back('0);
      exp_strb_q.push_back(16'h0000);
      exp_last_q.push_back(i == 15);
    end
    wait_bursts(6);
    check("flush_word1_strb", act_strb_q[flush_idx + 1], 16'h00FF);
    check("flush_pad_strb", act_strb_q[flush_idx + 2], 16'h0000);
    check("flush_wlast", act_last_q[flush_idx + 15], 1);

    // start of frame after a partial word -> restart at base, partial discarded
    tuser_idx = exp_data_q.size();
    send_beats(2, 32'hB0, 1'b0, 1'b0);
    send_beats(64, 32'h100, 1'b0, 1'b1);
    exp_full_burst(BASE, 32'h100);
    wait_bursts(7);
    check("sof_aw_addr", act_addr_q[6], 32'h10000000);
    check("sof_first_word", act_data_q[tuser_idx], {32'h103, 32'h102, 32'h101, 32'h100});

`ifdef AXIS2DDR_BRESP_ERR_EN
    resp_val = 2'b10;
    send_beats(64, 32'h200, 1'b0, 1'b0);
    exp_full_burst(BASE + 32'h100, 32'h200);
    wait_bursts(8);
    @(negedge clk);
    check("bresp_err_set", bresp_err, 1);
    resp_val = 2'b00;
    send_beats(64, 32'h300, 1'b0, 1'b0);
    exp_full_burst(BASE + 32'h200, 32'h300);
    wait_bursts(9);
    @(negedge clk);
    check("bresp_err_sticky", bresp_err, 1);
`endif

    // final scoreboard compare
    repeat (20) @(negedge clk);
    check("aw_count", act_addr_q.size(), exp_addr_q.size());
    check("beat_count", act_data_q.size(), exp_data_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < act_addr_q.size(); i++) begin
      check($sformatf("aw_addr[%0d]", i), act_addr_q[i], exp_addr_q[i]);
      check($sformatf("aw_len[%0d]", i), act_len_q[i], 8'd15);
      check($sformatf("aw_size[%0d]", i), act_size_q[i], 3'd4);
      check($sformatf("aw_burst[%0d]", i), act_burst_q[i], 2'b01);
    end
    for (int i = 0; i < exp_data_q.size() && i < act_data_q.size(); i++) begin
      check($sformatf("wdata[%0d]", i), act_data_q[i], exp_data_q[i]);
      check($sformatf("wstrb[%0d]", i), act_strb_q[i], exp_strb_q[i]);
      check($sformatf("wlast[%0d]", i), act_last_q[i], exp_last_q[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
